// File: rtl/nvram_ioctl_bridge.sv
// nvram_ioctl_bridge: serves HPS ioctl upload reads and download writes
// from/to a req/ack NVRAM port, with dirty tracking and load-done pulse.
module nvram_ioctl_bridge #(
    parameter logic [7:0] INDEX      = 8'd4,
    parameter int         ADDR_WIDTH = 7
) (
    input  logic                  clk_sys,
    input  logic                  RESET,
    input  logic                  ioctl_upload,
    input  logic                  ioctl_download,
    input  logic                  ioctl_rd,
    input  logic                  ioctl_wr,
    input  logic [7:0]            ioctl_index,
    input  logic [26:0]           ioctl_addr,
    input  logic [15:0]           ioctl_dout,
    output logic [15:0]           ioctl_din,
    output logic                  ioctl_wait,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack,
    input  logic                  game_wr,
    output logic                  dirty,
    output logic                  load_done
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        HOLD
    } state_t;

    state_t state;

    logic upload_q;
    logic download_q;
    logic idx_hit;
    logic claim_rd;
    logic claim_wr;
    logic out_of_range;
    logic up_fall;
    logic dn_fall;

    assign idx_hit      = (ioctl_index == INDEX);
    assign claim_rd     = (state == IDLE) && idx_hit && ioctl_rd && ioctl_upload;
    assign claim_wr     = (state == IDLE) && idx_hit && ioctl_wr && ioctl_download;
    assign out_of_range = |(ioctl_addr >> (ADDR_WIDTH + 1));
    assign up_fall      = upload_q && !ioctl_upload && idx_hit;
    assign dn_fall      = download_q && !ioctl_download && idx_hit;

    // Access FSM: claims strobes, drives the NVRAM port and the HPS stall.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 16'h0000;
            ioctl_din  <= 16'h0000;
            ioctl_wait <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Write wins if both strobes qualify together.
                    if (claim_wr) begin
                        ioctl_wait <= 1'b1;
                        if (out_of_range) begin
                            state <= HOLD;
                        end else begin
                            state     <= WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= ioctl_addr[ADDR_WIDTH:1];
                            mem_wdata <= ioctl_dout;
                        end
                    end else if (claim_rd) begin
                        ioctl_wait <= 1'b1;
                        if (out_of_range) begin
                            ioctl_din <= 16'hFFFF;
                            state     <= HOLD;
                        end else begin
                            state    <= RD;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= ioctl_addr[ADDR_WIDTH:1];
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        ioctl_din <= mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= HOLD;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    // Turnaround cycle before the next access can be claimed.
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Transfer-end detection: dirty tracking and post-restore load pulse.
    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            upload_q   <= 1'b0;
            download_q <= 1'b0;
            dirty      <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            upload_q   <= ioctl_upload;
            download_q <= ioctl_download;
            load_done  <= dn_fall;
            if (game_wr) begin
                dirty <= 1'b1;
            end else if (up_fall || dn_fall) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// tb_nvram_ioctl_bridge: directed stimulus with a queued scoreboard
// checked by an event monitor on the NVRAM and ioctl sides.
module tb_nvram_ioctl_bridge;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic        clk_sys;
    logic        RESET;
    logic        ioctl_upload;
    logic        ioctl_download;
    logic        ioctl_rd;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [26:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        game_wr;
    logic        dirty;
    logic        load_done;

    int   checks   = 0;
    int   failures = 0;
    int   ack_delay = 0;
    exp_t exp_q[$];
    logic [15:0] tbmem [128];

    nvram_ioctl_bridge #(
        .INDEX     (8'd4),
        .ADDR_WIDTH(7)
    ) dut (
        .clk_sys       (clk_sys),
        .RESET         (RESET),
        .ioctl_upload  (ioctl_upload),
        .ioctl_download(ioctl_download),
        .ioctl_rd      (ioctl_rd),
        .ioctl_wr      (ioctl_wr),
        .ioctl_index   (ioctl_index),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .game_wr       (game_wr),
        .dirty         (dirty),
        .load_done     (load_done)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_ev(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input string name, input logic [31:0] val);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s actual=%h required=none", name, val);
        end else begin
            e = exp_q.pop_front();
            if (e.name != name || e.val !== val) begin
                failures++;
                $display("FAIL %s actual=%s:%h required=%s:%h",
                         e.name, name, val, e.name, e.val);
            end
        end
    endtask

    // Monitor: NVRAM request starts, end-of-stall (length + din), load pulses.
    initial begin : monitor
        logic req_q;
        logic wait_q;
        int   wait_len;
        req_q    = 1'b0;
        wait_q   = 1'b0;
        wait_len = 0;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !req_q)
                observe("req", {8'h00, mem_we, mem_addr,
                                (mem_we ? mem_wdata : 16'h0000)});
            if (wait_q && !ioctl_wait) begin
                observe("wait", {8'h00, wait_len[7:0], ioctl_din});
                wait_len = 0;
            end
            if (ioctl_wait)
                wait_len++;
            if (load_done)
                observe("ld", 32'h1);
            req_q  = mem_req;
            wait_q = ioctl_wait;
        end
    end

    // NVRAM responder: acks ack_delay cycles after a request appears.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk_sys);
            if (mem_req) begin
                repeat (ack_delay) @(negedge clk_sys);
                if (mem_req) begin
                    mem_ack = 1'b1;
                    if (mem_we)
                        tbmem[mem_addr] = mem_wdata;
                    else
                        mem_rdata = tbmem[mem_addr];
                    @(negedge clk_sys);
                    mem_ack = 1'b0;
                end
            end
        end
    end

    task automatic do_rd(input logic [26:0] a, input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_addr  = a;
        ioctl_index = idx;
        ioctl_rd    = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
    endtask

    task automatic do_wr(input logic [26:0] a, input logic [15:0] d);
        @(negedge clk_sys);
        ioctl_addr  = a;
        ioctl_index = 8'd4;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk_sys);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_game_wr();
        @(negedge clk_sys);
        game_wr = 1'b1;
        @(negedge clk_sys);
        game_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++)
            tbmem[i] = 16'h1111;
        tbmem[2] = 16'hBEEF;
        tbmem[3] = 16'hA5C3;

        RESET          = 1'b1;
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_index    = 8'd4;
        ioctl_addr     = 27'h0;
        ioctl_dout     = 16'h0;
        game_wr        = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_wait", {31'h0, ioctl_wait}, 32'h0);
        chk("rst_din", {16'h0, ioctl_din}, 32'h0);
        chk("rst_misc", {dirty, load_done, mem_we, mem_addr, mem_wdata}, 32'h0);
        RESET = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Upload read, ack 3 cycles after request
        ioctl_upload = 1'b1;
        ack_delay    = 3;
        expect_ev("req", {8'h00, 1'b0, 7'd2, 16'h0000});
        expect_ev("wait", {16'h0005, 16'hBEEF});
        do_rd(27'h0004, 8'd4);
        drain();
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Download write with immediate ack, then load_done and dirty clear
        pulse_game_wr();
        chk("dirty_set", {31'h0, dirty}, 32'h1);
        ioctl_download = 1'b1;
        ack_delay      = 0;
        expect_ev("req", {8'h00, 1'b1, 7'd127, 16'h1234});
        expect_ev("wait", {16'h0002, 16'hBEEF});
        do_wr(27'h00FE, 16'h1234);
        drain();
        chk("mem_written", {16'h0, tbmem[127]}, 32'h1234);
        expect_ev("ld", 32'h1);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        drain();
        chk("dirty_clr_dl", {31'h0, dirty}, 32'h0);

        // Read back the written word, ack after 2 cycles
        ioctl_upload = 1'b1;
        ack_delay    = 2;
        expect_ev("req", {8'h00, 1'b0, 7'd127, 16'h0000});
        expect_ev("wait", {16'h0004, 16'h1234});
        do_rd(27'h00FE, 8'd4);
        drain();

        // Out-of-range read, then wrong index
        pulse_game_wr();
        expect_ev("wait", {16'h0001, 16'hFFFF});
        do_rd(27'h0100, 8'd4);
        drain();
        do_rd(27'h0004, 8'd3);
        repeat (4) @(negedge clk_sys);
        chk("wrong_idx_wait", {31'h0, ioctl_wait}, 32'h0);
        chk("wrong_idx_din", {16'h0, ioctl_din}, 32'hFFFF);
        ioctl_upload = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("dirty_keep_idx3", {31'h0, dirty}, 32'h1);

        // Out-of-range write is dropped
        ioctl_download = 1'b1;
        expect_ev("wait", {16'h0001, 16'hFFFF});
        do_wr(27'h0200, 16'hDEAD);
        drain();
        chk("oor_wr_dropped", {16'h0, tbmem[0]}, 32'h1111);
        expect_ev("ld", 32'h1);
        @(negedge clk_sys);
        ioctl_index    = 8'd4;
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        drain();
        chk("dirty_clr_dl2", {31'h0, dirty}, 32'h0);

        // Dirty: set, cleared by upload end, set wins on coincidence
        pulse_game_wr();
        chk("dirty_set2", {31'h0, dirty}, 32'h1);
        ioctl_upload = 1'b1;
        repeat (3) @(negedge clk_sys);
        ioctl_upload = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("dirty_clr_ul", {31'h0, dirty}, 32'h0);
        ioctl_upload = 1'b1;
        repeat (3) @(negedge clk_sys);
        ioctl_upload = 1'b0;
        game_wr      = 1'b1;
        @(negedge clk_sys);
        game_wr = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("dirty_set_wins", {31'h0, dirty}, 32'h1);

        // Reset in RD before ack
        ioctl_upload = 1'b1;
        ack_delay    = 10;
        expect_ev("req", {8'h00, 1'b0, 7'd3, 16'h0000});
        expect_ev("wait", {16'h0002, 16'h0000});
        do_rd(27'h0006, 8'd4);
        @(negedge clk_sys);
        #2;
        RESET = 1'b1;
        #1;
        chk("rst_async_req", {31'h0, mem_req}, 32'h0);
        chk("rst_async_wait", {31'h0, ioctl_wait}, 32'h0);
        repeat (2) @(negedge clk_sys);
        RESET = 1'b0;
        drain();
        chk("rst_din", {16'h0, ioctl_din}, 32'h0);
        repeat (15) @(negedge clk_sys);

        // Next read after reset is served normally
        ack_delay = 1;
        expect_ev("req", {8'h00, 1'b0, 7'd3, 16'h0000});
        expect_ev("wait", {16'h0003, 16'hA5C3});
        do_rd(27'h0006, 8'd4);
        drain();
        repeat (3) @(negedge clk_sys);
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nvram_ioctl_bridge.md
# nvram_ioctl_bridge

Bridges the HPS ioctl channel to the game's battery/EEPROM-style NVRAM so that settings and high scores can be saved to and restored from the SD card. Sits beside `hps_io` in `clk_sys`. For ioctl transfers carrying its own index it does two things:
- serves HPS upload reads (core → HPS) by fetching words from NVRAM;
- commits HPS download writes (HPS → core) into NVRAM.

Each NVRAM access uses a req/ack port and stalls the HPS with `ioctl_wait` until the access completes. It also tracks a dirty flag so the OSD can prompt for a save.

## Interface

Parameters:
- `INDEX`, default 8'd4: ioctl index claimed by this block.
- `ADDR_WIDTH`, default 7: NVRAM word-address width. Depth is 2^ADDR_WIDTH 16-bit words.

Ports:
- `clk_sys`, in, 1: system clock; all logic in this domain.
- `RESET`, in, 1: asynchronous, active-high reset.
- `ioctl_upload`, in, 1: HPS upload transfer active.
- `ioctl_download`, in, 1: HPS download transfer active.
- `ioctl_rd`, in, 1: upload read strobe, one cycle.
- `ioctl_wr`, in, 1: download write strobe, one cycle.
- `ioctl_index`, in, 8: transfer index.
- `ioctl_addr`, in, 27: byte address, always even.
- `ioctl_dout`, in, 16: download data from HPS.
- `ioctl_din`, out, 16: upload data to HPS.
- `ioctl_wait`, out, 1: stall request to HPS.
- `mem_req`, out, 1: NVRAM access request.
- `mem_we`, out, 1: 1 = write, 0 = read.
- `mem_addr`, out, ADDR_WIDTH: NVRAM word address.
- `mem_wdata`, out, 16: write data.
- `mem_rdata`, in, 16: read data, valid with `mem_ack`.
- `mem_ack`, in, 1: one-cycle access completion.
- `game_wr`, in, 1: pulse from the game side whenever it writes NVRAM.
- `dirty`, out, 1: NVRAM modified since the last save or load.
- `load_done`, out, 1: one-cycle pulse at the end of a claimed download.

## Operation

Claiming:
- A strobe is claimed only when all of the following hold: `ioctl_index == INDEX`, FSM is in IDLE, and the matching transfer flag is set (`ioctl_rd` with `ioctl_upload`, `ioctl_wr` with `ioctl_download`).
- If both strobes qualify in the same cycle (illegal from HPS), the write wins.
- All other strobes are ignored, with no side effects.

Address mapping:
- Word address = `ioctl_addr[ADDR_WIDTH:1]`.
- The access is out of range when any of `ioctl_addr[26:ADDR_WIDTH+1]` is nonzero.
- Out-of-range read: `ioctl_din` <= 16'hFFFF and no memory access is made.
- Out-of-range write: dropped.
- In both out-of-range cases `ioctl_wait` pulses high for exactly one cycle. This keeps the handshake uniform.

FSM states:
- **IDLE**:
  - Claimed in-range read → RD: load `mem_addr`, `mem_we` = 0, `mem_req` = 1.
  - Claimed in-range write → WR: also latch `mem_wdata` <= `ioctl_dout`, `mem_we` = 1.
  - Claimed out-of-range access → HOLD.
- **RD**: hold `mem_req`, `mem_addr` and `mem_we` stable. On `mem_ack`: `ioctl_din` <= `mem_rdata`, `mem_req` <= 0 → HOLD.
- **WR**: same as RD, but `ioctl_din` is untouched.
- **HOLD**: one cycle → IDLE. This guarantees a turnaround between accesses.

Wait generation:
- `ioctl_wait` is registered: 1 in RD, WR and HOLD, 0 in IDLE.
- `ioctl_din` is stable from its update until the next claimed read.

Transfer-flag drop mid-access:
- If `ioctl_upload` or `ioctl_download` falls during RD/WR, the access still completes normally.

Dirty flag:
- Set by `game_wr`.
- Cleared on the falling edge of `ioctl_upload` or `ioctl_download` when the transfer index matched at the falling edge.
- If `game_wr` coincides with a clearing edge, set wins.

Load done:
- `load_done` pulses one cycle on the falling edge of `ioctl_download` with matching index. It is intended to release the game CPU reset after a restore.
- The falling-edge detector registers the previous value of each transfer flag.

## Timing

Reset values: all outputs 0 except `ioctl_din` = 16'h0000; FSM = IDLE.

Reset mid-operation:
- FSM and all outputs return to reset values immediately, including `mem_req`.
- The NVRAM side must tolerate an abandoned request.

Latency, with the strobe in cycle 0:
- `mem_req` and `ioctl_wait` are high from cycle 1.
- The earliest `mem_ack` is in cycle 1.
- `ioctl_din` is valid and `mem_req` is low from cycle ack+1.
- `ioctl_wait` falls at cycle ack+2, after the HOLD cycle.

Minimum strobe spacing: 3 cycles. Strobes arriving while busy are ignored, because HPS honours `ioctl_wait`.

`mem_ack` sampled outside RD/WR is ignored.

## Test plan

1. **Reset values**: assert `RESET` → all outputs reset values, `mem_req` = 0, `ioctl_wait` = 0.
2. **Upload read**: `ioctl_upload` = 1, index 4, `ioctl_addr` = 0x0004, `ioctl_rd` pulse; `mem_ack` 3 cycles after `mem_req` with `mem_rdata` = 16'hBEEF → `mem_addr` = 2, `mem_we` = 0, `ioctl_din` = 16'hBEEF, `ioctl_wait` high for 5 cycles.
3. **Download write**: `ioctl_download` = 1, `ioctl_addr` = 0x00FE, `ioctl_dout` = 16'h1234, immediate ack → `mem_addr` = 127, `mem_we` = 1, `mem_wdata` = 16'h1234. On download fall: `load_done` pulses once and `dirty` clears.
4. **Out of range and wrong index**: read at `ioctl_addr` = 0x0100 → `ioctl_din` = 16'hFFFF, no `mem_req`, `ioctl_wait` high 1 cycle. Strobe with index 3 → no response at all.
5. **Dirty flag**: `game_wr` pulse → `dirty` = 1. Upload at index 4 ends → `dirty` = 0. `game_wr` in the same cycle as the upload fall → `dirty` remains 1.
6. **Reset mid-access**: `RESET` asserted in RD before ack → `mem_req` and `ioctl_wait` drop asynchronously. The next read after reset is served normally.
